// File: rtl/mem64.sv
// Card-board memory: 64 x 5-bit register file with a registered read port,
// a write port and an atomic two-address swap port. Reset loads the default deal.
module mem64 #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CARDS = 36,
  parameter int unsigned EMPTY = 31
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [$clog2(DEPTH)-1:0] rAddr,
  output logic [WIDTH-1:0]         dataOut,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wAddr,
  input  logic [WIDTH-1:0]         wData,
  input  logic                     swap,
  input  logic [$clog2(DEPTH)-1:0] sAddrA,
  input  logic [$clog2(DEPTH)-1:0] sAddrB
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Playable slots hold each pair value twice (a mod CARDS/2); the rest are EMPTY.
  function automatic logic [WIDTH-1:0] default_val(input int unsigned idx);
    if (idx < CARDS) return WIDTH'(idx % (CARDS / 2));
    else             return WIDTH'(EMPTY);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= default_val(i);
      dataOut <= '0;
    end else begin
      // Read samples pre-edge contents, so both write and swap are read-first.
      dataOut <= mem[rAddr];
      if (swap) begin
        // Equal addresses write back the same value, leaving memory unchanged.
        mem[sAddrA] <= mem[sAddrB];
        mem[sAddrB] <= mem[sAddrA];
      end else if (we) begin
        mem[wAddr] <= wData;
      end
    end
  end

endmodule

// File: tb/tb_mem64.sv
// Directed self-checking bench for mem64: reset layout, read latency,
// read-first writes, swaps, swap-over-write priority and mid-run reset.
module tb_mem64;

  logic       clock;
  logic       reset_n;
  logic [5:0] rAddr;
  logic [4:0] dataOut;
  logic       we;
  logic [5:0] wAddr;
  logic [4:0] wData;
  logic       swap;
  logic [5:0] sAddrA;
  logic [5:0] sAddrB;

  int checks = 0;
  int errors = 0;

  mem64 #(.DEPTH(64), .WIDTH(5), .CARDS(36), .EMPTY(31)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rAddr   (rAddr),
    .dataOut (dataOut),
    .we      (we),
    .wAddr   (wAddr),
    .wData   (wData),
    .swap    (swap),
    .sAddrA  (sAddrA),
    .sAddrB  (sAddrB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] layout(input int a);
    return (a < 36) ? 5'(a % 18) : 5'd31;
  endfunction

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (dataOut !== 5'd0) begin
      errors++;
      $display("FAIL reset_dataout: got %0d, required 0", dataOut);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int a = 0; a < 64; a++) begin
      rAddr = 6'(a);
      step();
      checks++;
      if (dataOut !== layout(a)) begin
        errors++;
        $display("FAIL reset_layout addr %0d: got %0d, required %0d", a, dataOut, layout(a));
      end
    end
  endtask

  task automatic test_pair_count();
    int cnt [18];
    for (int v = 0; v < 18; v++) cnt[v] = 0;
    for (int a = 0; a < 36; a++) begin
      rAddr = 6'(a);
      step();
      if (dataOut < 5'd18) cnt[dataOut] = cnt[dataOut] + 1;
    end
    for (int v = 0; v < 18; v++) begin
      checks++;
      if (cnt[v] !== 2) begin
        errors++;
        $display("FAIL pair_count value %0d: got %0d occurrences, required 2", v, cnt[v]);
      end
    end
  endtask

  task automatic test_read_during_write();
    rAddr = 6'd40; we = 1'b1; wAddr = 6'd40; wData = 5'd9;
    step();
    we = 1'b0;
    checks++;
    if (dataOut !== 5'd31) begin
      errors++;
      $display("FAIL rdw_old: got %0d, required 31", dataOut);
    end
    step();
    checks++;
    if (dataOut !== 5'd9) begin
      errors++;
      $display("FAIL rdw_new: got %0d, required 9", dataOut);
    end
  endtask

  task automatic test_swap();
    rAddr = 6'd0; swap = 1'b1; sAddrA = 6'd0; sAddrB = 6'd35;
    step();
    swap = 1'b0;
    checks++;
    if (dataOut !== 5'd0) begin
      errors++;
      $display("FAIL swap_read_first: got %0d, required 0", dataOut);
    end
    rAddr = 6'd0; step();
    checks++;
    if (dataOut !== 5'd17) begin
      errors++;
      $display("FAIL swap_addr0: got %0d, required 17", dataOut);
    end
    rAddr = 6'd35; step();
    checks++;
    if (dataOut !== 5'd0) begin
      errors++;
      $display("FAIL swap_addr35: got %0d, required 0", dataOut);
    end
    swap = 1'b1; sAddrA = 6'd3; sAddrB = 6'd3;
    step();
    swap = 1'b0;
    rAddr = 6'd3; step();
    checks++;
    if (dataOut !== 5'd3) begin
      errors++;
      $display("FAIL swap_self: got %0d, required 3", dataOut);
    end
  endtask

  task automatic test_swap_priority();
    int found;
    swap = 1'b1; sAddrA = 6'd1; sAddrB = 6'd2;
    we = 1'b1; wAddr = 6'd1; wData = 5'd20;
    step();
    swap = 1'b0; we = 1'b0;
    rAddr = 6'd1; step();
    checks++;
    if (dataOut !== 5'd2) begin
      errors++;
      $display("FAIL prio_addr1: got %0d, required 2", dataOut);
    end
    rAddr = 6'd2; step();
    checks++;
    if (dataOut !== 5'd1) begin
      errors++;
      $display("FAIL prio_addr2: got %0d, required 1", dataOut);
    end
    found = 0;
    for (int a = 0; a < 64; a++) begin
      rAddr = 6'(a);
      step();
      if (dataOut === 5'd20) found++;
    end
    checks++;
    if (found !== 0) begin
      errors++;
      $display("FAIL prio_no_20: got %0d entries holding 20, required 0", found);
    end
    // Disjoint write address is dropped too.
    swap = 1'b1; sAddrA = 6'd10; sAddrB = 6'd11;
    we = 1'b1; wAddr = 6'd50; wData = 5'd7;
    step();
    swap = 1'b0; we = 1'b0;
    rAddr = 6'd50; step();
    checks++;
    if (dataOut !== 5'd31) begin
      errors++;
      $display("FAIL prio_addr50: got %0d, required 31", dataOut);
    end
    rAddr = 6'd10; step();
    checks++;
    if (dataOut !== 5'd11) begin
      errors++;
      $display("FAIL prio_addr10: got %0d, required 11", dataOut);
    end
    rAddr = 6'd11; step();
    checks++;
    if (dataOut !== 5'd10) begin
      errors++;
      $display("FAIL prio_addr11: got %0d, required 10", dataOut);
    end
  endtask

  task automatic test_back_to_back();
    we = 1'b1; wAddr = 6'd63; wData = 5'd4;
    step();
    wAddr = 6'd36; wData = 5'd22;
    step();
    wAddr = 6'd37; wData = 5'd0;
    step();
    we = 1'b0;
    rAddr = 6'd63; step();
    checks++;
    if (dataOut !== 5'd4) begin
      errors++;
      $display("FAIL b2b_addr63: got %0d, required 4", dataOut);
    end
    rAddr = 6'd36; step();
    checks++;
    if (dataOut !== 5'd22) begin
      errors++;
      $display("FAIL b2b_addr36: got %0d, required 22", dataOut);
    end
    rAddr = 6'd37; step();
    checks++;
    if (dataOut !== 5'd0) begin
      errors++;
      $display("FAIL b2b_addr37: got %0d, required 0", dataOut);
    end
  endtask

  task automatic test_reset_mid();
    we = 1'b1; wAddr = 6'd5; wData = 5'd12;
    step();
    we = 1'b0;
    rAddr = 6'd5; step();
    checks++;
    if (dataOut !== 5'd12) begin
      errors++;
      $display("FAIL mid_pre_write: got %0d, required 12", dataOut);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (dataOut !== 5'd0) begin
      errors++;
      $display("FAIL mid_async_clear: got %0d, required 0", dataOut);
    end
    // Commands presented across an edge while reset is held must be ignored.
    we = 1'b1; wAddr = 6'd5; wData = 5'd12;
    swap = 1'b1; sAddrA = 6'd6; sAddrB = 6'd7;
    @(posedge clock);
    @(negedge clock);
    we = 1'b0; swap = 1'b0;
    reset_n = 1'b1;
    rAddr = 6'd5; step();
    checks++;
    if (dataOut !== 5'd5) begin
      errors++;
      $display("FAIL mid_addr5: got %0d, required 5", dataOut);
    end
    rAddr = 6'd0; step();
    checks++;
    if (dataOut !== 5'd0) begin
      errors++;
      $display("FAIL mid_addr0: got %0d, required 0", dataOut);
    end
    rAddr = 6'd6; step();
    checks++;
    if (dataOut !== 5'd6) begin
      errors++;
      $display("FAIL mid_addr6: got %0d, required 6", dataOut);
    end
    rAddr = 6'd40; step();
    checks++;
    if (dataOut !== 5'd31) begin
      errors++;
      $display("FAIL mid_addr40: got %0d, required 31", dataOut);
    end
  endtask

  task automatic test_first_edge_after_reset();
    #2 reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    we = 1'b1; wAddr = 6'd8; wData = 5'd30;
    step();
    we = 1'b0;
    rAddr = 6'd8; step();
    checks++;
    if (dataOut !== 5'd30) begin
      errors++;
      $display("FAIL first_edge_write: got %0d, required 30", dataOut);
    end
  endtask

  initial begin
    rAddr = '0; we = 1'b0; wAddr = '0; wData = '0;
    swap = 1'b0; sAddrA = '0; sAddrB = '0;
    test_reset();
    test_pair_count();
    test_read_during_write();
    test_swap();
    test_swap_priority();
    test_back_to_back();
    test_reset_mid();
    test_first_edge_after_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem64.md
MEM64 -- requirements
Module: mem64

Interface
REQ-001 Parameter DEPTH, default 64: number of entries, addressed 0..63.
REQ-002 Parameter WIDTH, default 5: data bits per entry.
REQ-003 Parameter CARDS, default 36: number of playable card slots (6x6 board).
REQ-004 Parameter EMPTY, default 31: value held by unused slots.
REQ-005 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port rAddr, input, 6 bits: read address.
REQ-008 Port dataOut, output, 5 bits: registered read data.
REQ-009 Port we, input, 1 bit: write enable.
REQ-010 Port wAddr, input, 6 bits: write address.
REQ-011 Port wData, input, 5 bits: write data.
REQ-012 Port swap, input, 1 bit: swap request.
REQ-013 Port sAddrA, input, 6 bits: first address of the swap.
REQ-014 Port sAddrB, input, 6 bits: second address of the swap.

Function
REQ-015 Storage SHALL be 64 x 5-bit registers, resettable as a block; no RAM macro inference is required.
REQ-016 Default layout SHALL place value (a mod 18) at each address a in 0..35, so that values 0..17 each occur exactly twice; addresses 36..63 SHALL hold EMPTY (31).
REQ-017 Read: at each rising edge, dataOut SHALL load mem[rAddr]; latency is one cycle, and the read is always enabled.
REQ-018 A write SHALL occur when we=1: mem[wAddr] <= wData at the rising edge.
REQ-019 Read-during-write to the same address SHALL be read-first: dataOut gets the old value, and the new value is visible one cycle later.
REQ-020 A swap SHALL occur when swap=1: mem[sAddrA] and mem[sAddrB] are exchanged atomically in one edge.
REQ-021 A swap with sAddrA == sAddrB SHALL leave memory unchanged.
REQ-022 Priority: when swap=1 and we=1 in the same cycle, the swap SHALL execute and the write SHALL be dropped entirely, whatever the addresses.
REQ-023 Read-during-swap SHALL return pre-swap contents.
REQ-024 Writes and swaps SHALL be accepted at any address 0..63, including the EMPTY region; there is no address checking.
REQ-025 Only the low 5 bits are stored; wData is already 5 bits wide, so there is no truncation logic.
REQ-026 There is no handshake: each command completes in a single cycle, and back-to-back commands are legal every cycle.

Reset
REQ-027 While reset_n=0, asynchronously and regardless of clock, all entries SHALL take the default layout of REQ-016 and dataOut SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL abort any same-edge write or swap; memory SHALL equal the default layout.
REQ-029 After reset_n rises, the first rising edge SHALL perform a normal read, write or swap.
REQ-030 At power-up, before any reset, contents are unspecified; users SHALL apply a reset pulse.

Verification
REQ-031 Reset, then read addresses 0..63 sequentially -> dataOut one cycle later equals 0,1,..,17,0,..,17, then 31 for addresses 36..63.
REQ-032 Write 5'd9 to addr 40 while rAddr=40 -> that cycle's dataOut is 31; the next cycle's dataOut is 9.
REQ-033 Swap addr 0 and addr 35 (values 0 and 17) -> subsequent reads return 17 at addr 0 and 0 at addr 35; a swap of 3 with 3 leaves 3.
REQ-034 Same cycle: swap 1 and 2 plus write addr 1 = 20 -> addr 1 reads 2 and addr 2 reads 1; the value 20 appears nowhere.
REQ-035 Write addr 5 = 12, then pulse reset_n low between clock edges -> dataOut immediately goes 0, and addr 5 reads 5 afterwards.
REQ-036 Exercise every value pair: count occurrences over addr 0..35 after reset -> each value 0..17 appears exactly twice.
